// File: rtl/omsp_hmac_tag_reader_pkg.sv
// Shared constants for the HMAC tag reader: tag geometry and FSM state encoding.
package omsp_hmac_tag_reader_pkg;

    localparam int HMAC_TAG_WORDS = 8;
    localparam int HMAC_IDX_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAPT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/omsp_hmac_tag_reader.sv
// Pulls the HMAC tag out of the 16-bit wrapper word by word, stores it into the
// tag buffer and optionally compares it against an expected tag in constant time.
module omsp_hmac_tag_reader
    import omsp_hmac_tag_reader_pkg::*;
#(
    parameter int TAG_WORDS = HMAC_TAG_WORDS,
    parameter int IDX_W     = HMAC_IDX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             verify,
    input  logic [15:0]      exp_word,
    input  logic             hmac_busy,
    input  logic [15:0]      hmac_data_out,
    output logic             hmac_start_continue,
    output logic             hmac_data_available,
    output logic             hmac_data_is_long,
    output logic [IDX_W-1:0] exp_idx,
    output logic             tag_we,
    output logic [IDX_W-1:0] tag_widx,
    output logic [15:0]      tag_wdata,
    output logic             busy,
    output logic             done,
    output logic             match
);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  counter_reg, counter_next;
    logic              acc_reg, acc_next;
    logic              verify_reg, verify_next;
    logic              match_reg, match_next;

    logic              last_word;
    logic              word_diff;

    assign last_word = (counter_reg == IDX_W'(TAG_WORDS - 1));
    // Full-width compare every word regardless of verify so timing never depends on data.
    assign word_diff = |(hmac_data_out ^ exp_word);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            counter_reg <= '0;
            acc_reg     <= 1'b0;
            verify_reg  <= 1'b0;
            match_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            acc_reg     <= acc_next;
            verify_reg  <= verify_next;
            match_reg   <= match_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        counter_next        = counter_reg;
        acc_next            = acc_reg;
        verify_next         = verify_reg;
        match_next          = match_reg;
        hmac_start_continue = 1'b0;
        tag_we              = 1'b0;
        tag_wdata           = '0;
        done                = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_REQ;
                    verify_next  = verify;
                    counter_next = '0;
                    acc_next     = 1'b0;
                    match_next   = 1'b0;
                end
            end
            ST_REQ: begin
                hmac_start_continue = 1'b1;
                state_next          = ST_WAIT;
            end
            ST_WAIT: begin
                // The wrapper raises busy together with the request, so it is only
                // trusted from the cycle after REQ onwards.
                if (!hmac_busy) begin
                    state_next = ST_CAPT;
                end
            end
            ST_CAPT: begin
                tag_we    = 1'b1;
                tag_wdata = hmac_data_out;
                acc_next  = acc_reg | (verify_reg & word_diff);
                if (last_word) begin
                    state_next = ST_DONE;
                    // Result is settled here so it is already valid while done is high.
                    match_next = verify_reg & ~acc_next;
                end else begin
                    counter_next = counter_reg + 1'b1;
                    state_next   = ST_REQ;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign hmac_data_available = 1'b0;
    assign hmac_data_is_long   = 1'b0;
    assign exp_idx             = counter_reg;
    assign tag_widx            = counter_reg;
    assign busy                = (state_reg != ST_IDLE);
    assign match               = match_reg;

endmodule

// File: tb/tb_omsp_hmac_tag_reader.sv
// Bench for omsp_hmac_tag_reader: vector table of full tag reads against a
// 2-wait-cycle wrapper model, plus hand-written reset sequences.
module tb_omsp_hmac_tag_reader;

    localparam int TW       = 8;
    localparam int IDX_W    = 3;
    localparam int BUSY_CYC = 2;
    localparam int EXP_CYC  = TW * (3 + BUSY_CYC) + 1;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             verify;
    logic [15:0]      exp_word;
    logic             hmac_busy;
    logic [15:0]      hmac_data_out;
    logic             hmac_start_continue;
    logic             hmac_data_available;
    logic             hmac_data_is_long;
    logic [IDX_W-1:0] exp_idx;
    logic             tag_we;
    logic [IDX_W-1:0] tag_widx;
    logic [15:0]      tag_wdata;
    logic             busy;
    logic             done;
    logic             match;

    logic [15:0]      exp_tab [TW];
    logic             model_clr;
    int               model_req;
    int               model_bcnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        vrf;
        int          bad_idx;
        logic [15:0] bad_val;
        logic        exp_match;
        int          glitch_word;
    } vec_t;

    vec_t vecs [5];

    omsp_hmac_tag_reader #(.TAG_WORDS(TW), .IDX_W(IDX_W)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .verify              (verify),
        .exp_word            (exp_word),
        .hmac_busy           (hmac_busy),
        .hmac_data_out       (hmac_data_out),
        .hmac_start_continue (hmac_start_continue),
        .hmac_data_available (hmac_data_available),
        .hmac_data_is_long   (hmac_data_is_long),
        .exp_idx             (exp_idx),
        .tag_we              (tag_we),
        .tag_widx            (tag_widx),
        .tag_wdata           (tag_wdata),
        .busy                (busy),
        .done                (done),
        .match               (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign exp_word = exp_tab[exp_idx];

    // Wrapper model: busy rises with the request and stays up BUSY_CYC more cycles;
    // word n of a run is 0x1111*n.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_req     <= 0;
            model_bcnt    <= 0;
            hmac_data_out <= '0;
        end else if (model_clr) begin
            model_req <= 0;
        end else if (hmac_start_continue) begin
            hmac_data_out <= 16'(16'h1111 * model_req);
            model_req     <= model_req + 1;
            model_bcnt    <= BUSY_CYC;
        end else if (model_bcnt != 0) begin
            model_bcnt <= model_bcnt - 1;
        end
    end
    assign hmac_busy = hmac_start_continue | (model_bcnt != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_match"}, 32'(match), 0);
        chk({tag, "_tag_we"}, 32'(tag_we), 0);
        chk({tag, "_req"}, 32'(hmac_start_continue), 0);
        chk({tag, "_exp_idx"}, 32'(exp_idx), 0);
        chk({tag, "_avail"}, 32'(hmac_data_available), 0);
        chk({tag, "_long"}, 32'(hmac_data_is_long), 0);
    endtask

    task automatic load_exp(input int bad_idx, input logic [15:0] bad_val);
        for (int i = 0; i < TW; i++) exp_tab[i] = 16'(16'h1111 * i);
        if (bad_idx >= 0) exp_tab[bad_idx] = bad_val;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int  cyc;
        int  we_cnt;
        int  req_cnt;
        bit  got_done;
        bit  glitch_armed;
        cyc = 1; we_cnt = 0; req_cnt = 0; got_done = 0; glitch_armed = 0;
        load_exp(v.bad_idx, v.bad_val);
        @(negedge clk);
        model_clr = 1'b1; verify = v.vrf; start = 1'b1;
        @(negedge clk);
        model_clr = 1'b0; verify = 1'b0; start = 1'b0;
        chk("start_clears_match", 32'(match), 0);
        chk("busy_after_start", 32'(busy), 1);
        while (cyc <= 200) begin
            if (start) begin
                start = 1'b0;
            end else if (glitch_armed) begin
                start = 1'b1;
                verify = ~v.vrf;
                glitch_armed = 0;
            end
            if (tag_we) begin
                chk("tag_widx", 32'(tag_widx), 32'(we_cnt));
                chk("tag_wdata", 32'(tag_wdata), 32'(16'(16'h1111 * we_cnt)));
                we_cnt++;
            end
            if (hmac_start_continue) begin
                if (v.glitch_word == int'(exp_idx)) glitch_armed = 1;
                req_cnt++;
            end
            if (done) begin
                got_done = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        verify = 1'b0;
        if (!got_done) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("run_cycles", 32'(cyc), 32'(EXP_CYC));
            chk("match_at_done", 32'(match), 32'(v.exp_match));
            chk("words_written", 32'(we_cnt), 32'(TW));
            chk("words_requested", 32'(req_cnt), 32'(TW));
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("done_single_pulse", 32'(done), 0);
                chk("busy_after_done", 32'(busy), 0);
                chk("match_holds", 32'(match), 32'(v.exp_match));
            end
        end
        $display("run %0d: verify=%0b glitch_word=%0d cycles=%0d words=%0d match=%0b",
                 id, v.vrf, v.glitch_word, cyc, we_cnt, match);
    endtask

    initial begin
        int wait_cyc;
        reset_n = 1'b0; start = 1'b0; verify = 1'b0; model_clr = 1'b0;
        load_exp(-1, 16'h0);

        vecs[0] = '{vrf: 1'b0, bad_idx: -1, bad_val: 16'h0000, exp_match: 1'b0, glitch_word: -1};
        vecs[1] = '{vrf: 1'b1, bad_idx: -1, bad_val: 16'h0000, exp_match: 1'b1, glitch_word: -1};
        vecs[2] = '{vrf: 1'b1, bad_idx:  0, bad_val: 16'hDEAD, exp_match: 1'b0, glitch_word: -1};
        vecs[3] = '{vrf: 1'b1, bad_idx:  7, bad_val: 16'h7776, exp_match: 1'b0, glitch_word: -1};
        vecs[4] = '{vrf: 1'b1, bad_idx: -1, bad_val: 16'h0000, exp_match: 1'b1, glitch_word:  3};

        // Start held together with reset must be ignored.
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check_idle_outputs("in_reset");
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Reset during WAIT of word 5, then a clean restart from index 0.
        load_exp(-1, 16'h0);
        @(negedge clk);
        model_clr = 1'b1; verify = 1'b1; start = 1'b1;
        @(negedge clk);
        model_clr = 1'b0; verify = 1'b0; start = 1'b0;
        wait_cyc = 0;
        while (!(hmac_start_continue && exp_idx == 3'd5) && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("reach_word5_req", 32'(hmac_start_continue && exp_idx == 3'd5), 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_run_reset");
        reset_n = 1'b1;
        $display("run reset: reset_n pulsed in WAIT of word 5");
        @(negedge clk);
        run_vec(5, vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
